// File: rtl/cmd_initiator.sv
// Remote-side command initiator: sends cmd + 16-bit data as three UART bytes,
// waits for a one-byte response and retransmits the frame on timeout.
module cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned MAX_RETRY      = 2,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        send_cmd,
    input  logic        clr_resp_rdy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        ack,
    output logic        timeout_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_HI,
        TX_LO,
        WAIT_RESP
    } state_t;

    state_t state, next_state;

    logic          launched;
    logic [7:0]    cmd_q;
    logic [15:0]   data_q;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;

    logic       in_tx;
    logic       accept;
    logic       launch;
    logic       byte_done;
    logic       capture;
    logic       timer_end;
    logic       retry;
    logic [7:0] tx_byte;

    always_comb begin
        next_state = state;
        in_tx      = 1'b0;
        accept     = 1'b0;
        launch     = 1'b0;
        byte_done  = 1'b0;
        capture    = 1'b0;
        timer_end  = 1'b0;
        retry      = 1'b0;
        tx_byte    = cmd_q;

        unique case (state)
            IDLE: begin
                if (send_cmd) begin
                    accept     = 1'b1;
                    next_state = TX_CMD;
                end
            end
            TX_CMD, TX_HI, TX_LO: begin
                in_tx = 1'b1;
                // tx_done only counts once this state's byte has been strobed out
                launch    = !launched;
                byte_done = launched && tx_done;
                case (state)
                    TX_HI:   tx_byte = data_q[15:8];
                    TX_LO:   tx_byte = data_q[7:0];
                    default: tx_byte = cmd_q;
                endcase
                if (byte_done) begin
                    case (state)
                        TX_CMD:  next_state = TX_HI;
                        TX_HI:   next_state = TX_LO;
                        default: next_state = WAIT_RESP;
                    endcase
                end
            end
            WAIT_RESP: begin
                if (rx_rdy && !clr_rx_rdy) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (timer == TIMER_LAST) begin
                    timer_end = 1'b1;
                    if (retry_cnt < RETRY_LAST) begin
                        retry      = 1'b1;
                        next_state = TX_CMD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launched    <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            timer       <= '0;
            retry_cnt   <= '0;
            tx_data     <= '0;
            trmt        <= 1'b0;
            clr_rx_rdy  <= 1'b0;
            busy        <= 1'b0;
            cmd_sent    <= 1'b0;
            resp        <= '0;
            resp_rdy    <= 1'b0;
            ack         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (next_state != state) begin
                launched <= 1'b0;
            end else if (launch) begin
                launched <= 1'b1;
            end

            trmt <= launch;
            if (launch) begin
                tx_data <= tx_byte;
            end

            // busy rises once the first TX state is live and falls with the final decision
            busy       <= (state != IDLE) && (next_state != IDLE);
            cmd_sent   <= byte_done && (state == TX_LO);
            clr_rx_rdy <= (in_tx && rx_rdy && !clr_rx_rdy) || capture;

            if (state == WAIT_RESP) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            if (accept) begin
                cmd_q       <= cmd;
                data_q      <= data;
                ack         <= 1'b0;
                timeout_err <= 1'b0;
                retry_cnt   <= '0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + RW'(1);
            end

            if (timer_end && !retry) begin
                timeout_err <= 1'b1;
            end

            if (capture) begin
                resp     <= rx_data;
                ack      <= (rx_data == ACK_BYTE);
                resp_rdy <= 1'b1;
            end else if (accept || clr_resp_rdy) begin
                resp_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// Self-checking bench for cmd_initiator: directed and randomized frames against
// a frame-level model (expected byte stream, attempt count, final flags).
module tb_cmd_initiator;

    localparam int unsigned TO  = 64;
    localparam int unsigned MR  = 2;
    localparam logic [7:0]  ACK = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] data = '0;
    logic        send_cmd = 1'b0;
    logic        clr_resp_rdy = 1'b0;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        ack;
    logic        timeout_err;

    cmd_initiator #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR),
        .ACK_BYTE(ACK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .data(data),
        .send_cmd(send_cmd),
        .clr_resp_rdy(clr_resp_rdy),
        .tx_data(tx_data),
        .trmt(trmt),
        .tx_done(tx_done),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy),
        .busy(busy),
        .cmd_sent(cmd_sent),
        .resp(resp),
        .resp_rdy(resp_rdy),
        .ack(ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;

    // Monitor-owned activity record
    int         cyc = 0;
    int         trmt_cnt = 0;
    int         cs_cnt = 0;
    int         clr_cnt = 0;
    int         tx_timer = 0;
    int         last_cs_cyc = 0;
    int         to_cyc = 0;
    logic       to_prev = 1'b0;
    logic [7:0] sent_q[$];

    // Bench-owned per-frame baselines
    int trmt_base = 0;
    int cs_base = 0;
    int clr_base = 0;

    always @(posedge clk) cyc++;

    // UART transmitter model: tx_done 20 cycles after each trmt
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (tx_timer != 0) begin
            tx_timer--;
            if (tx_timer == 0) tx_done = 1'b1;
        end
        if (trmt) begin
            trmt_cnt++;
            sent_q.push_back(tx_data);
            tx_timer = 20;
        end
        if (cmd_sent) begin
            cs_cnt++;
            last_cs_cyc = cyc;
        end
        if (clr_rx_rdy) clr_cnt++;
        if (timeout_err && !to_prev) to_cyc = cyc;
        to_prev = timeout_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic bound_fail(input string tag, input int obs, input int exp);
        tests++;
        failures++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_sent(input int n);
        int b = 0;
        while (sent_q.size() < n && b < 2000) begin
            tick;
            b++;
        end
        if (sent_q.size() < n) bound_fail("wait_sent", sent_q.size(), n);
    endtask

    task automatic wait_cs(input int n);
        int b = 0;
        while ((cs_cnt - cs_base) < n && b < 3000) begin
            tick;
            b++;
        end
        if ((cs_cnt - cs_base) < n) bound_fail("wait_cmd_sent", cs_cnt - cs_base, n);
    endtask

    task automatic wait_idle;
        int b = 0;
        while (busy && b < 3000) begin
            tick;
            b++;
        end
        if (busy) bound_fail("wait_idle", 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_trmt"}, trmt, 0);
        check({tag, "_clr_rx_rdy"}, clr_rx_rdy, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_sent"}, cmd_sent, 0);
        check({tag, "_resp"}, resp, 0);
        check({tag, "_resp_rdy"}, resp_rdy, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // resp_at: attempt (1..MR+1) whose wait window gets a response, 0 = never answer
    task automatic run_frame(input logic [7:0] c, input logic [15:0] d, input int resp_at,
                             input logic [7:0] rb, input int dly, input bit spam,
                             input bit stale, input bit clr_cap);
        int         attempts;
        int         nb;
        int         q0;
        logic [7:0] frame [3];
        tick;
        q0        = sent_q.size();
        trmt_base = trmt_cnt;
        cs_base   = cs_cnt;
        clr_base  = clr_cnt;
        cmd       = c;
        data      = d;
        send_cmd  = 1'b1;
        tick;
        send_cmd = 1'b0;
        check("busy_after_accept", busy, 0);
        check("trmt_after_accept", trmt, 0);
        tick;
        check("busy_launch", busy, 1);
        check("trmt_launch", trmt, 1);
        check("tx_data_launch", tx_data, c);

        if (spam) begin
            repeat (3) tick;
            cmd      = '0;
            data     = '0;
            send_cmd = 1'b1;
            repeat (30) tick;
            send_cmd = 1'b0;
        end

        if (stale) begin
            wait_sent(q0 + 2);
            rx_data = 8'h77;
            rx_rdy  = 1'b1;
            tick;
            check("stale_clr_rx_rdy", clr_rx_rdy, 1);
            rx_rdy = 1'b0;
            tick;
            check("stale_clr_drop", clr_rx_rdy, 0);
            check("stale_resp_rdy", resp_rdy, 0);
        end

        if (resp_at > 0) begin
            wait_cs(resp_at);
            repeat (dly) tick;
            rx_data      = rb;
            rx_rdy       = 1'b1;
            clr_resp_rdy = clr_cap;
            tick;
            clr_resp_rdy = 1'b0;
            check("cap_resp_rdy", resp_rdy, 1);
            check("cap_ack", ack, (rb == ACK));
            check("cap_busy", busy, 0);
            check("cap_clr_rx_rdy", clr_rx_rdy, 1);
            rx_rdy = 1'b0;
            tick;
            check("cap_clr_drop", clr_rx_rdy, 0);
        end

        wait_idle;
        repeat (2) tick;

        attempts = (resp_at > 0) ? resp_at : int'(MR) + 1;
        frame[0] = c;
        frame[1] = d[15:8];
        frame[2] = d[7:0];
        nb = sent_q.size() - q0;
        check("byte_count", nb, 3 * attempts);
        for (int i = 0; i < nb && i < 3 * attempts; i++)
            check($sformatf("byte%0d", i), sent_q[q0 + i], frame[i % 3]);
        check("trmt_pulses", trmt_cnt - trmt_base, 3 * attempts);
        check("cmd_sent_pulses", cs_cnt - cs_base, attempts);
        check("clr_rx_pulses", clr_cnt - clr_base, (resp_at > 0 ? 1 : 0) + (stale ? 1 : 0));
        check("final_resp_rdy", resp_rdy, (resp_at > 0));
        check("final_timeout_err", timeout_err, (resp_at == 0));
        check("final_busy", busy, 0);
        if (resp_at > 0) begin
            check("final_resp", resp, rb);
            check("final_ack", ack, (rb == ACK));
        end else begin
            check("final_ack", ack, 0);
            check("timeout_latency", to_cyc - last_cs_cyc, TO);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         ra;
        int         q0;
        logic [7:0] rb;
        logic [7:0] rc;
        logic [15:0] rd;

        #3;
        check_all_zero("reset");
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        // ACK response, then clr_resp_rdy clears only resp_rdy
        run_frame(8'h99, 16'hF0F0, 1, 8'hA5, 5, 1'b0, 1'b0, 1'b0);
        clr_resp_rdy = 1'b1;
        tick;
        clr_resp_rdy = 1'b0;
        check("clr_resp_rdy", resp_rdy, 0);
        check("clr_keeps_ack", ack, 1);
        check("clr_keeps_resp", resp, 8'hA5);

        // NACK: frame ends, no retry
        run_frame(8'h99, 16'hF0F0, 1, 8'h5A, 7, 1'b0, 1'b0, 1'b0);
        // No response at all: three attempts then timeout_err
        run_frame(8'h3C, 16'h1234, 0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        // Answer during second attempt
        run_frame(8'h11, 16'h2233, 2, 8'hA5, 10, 1'b0, 1'b0, 1'b0);
        // send_cmd while busy is ignored
        run_frame(8'hFF, 16'hFFFF, 1, 8'hA5, 3, 1'b1, 1'b0, 1'b0);
        // Stale byte in TX_HI, and clr_resp_rdy coinciding with capture
        run_frame(8'h42, 16'hBEEF, 1, 8'hA5, 2, 1'b0, 1'b1, 1'b1);

        // Reset during TX_LO
        tick;
        q0       = sent_q.size();
        cmd      = 8'h3C;
        data     = 16'h1234;
        send_cmd = 1'b1;
        tick;
        send_cmd = 1'b0;
        wait_sent(q0 + 3);
        repeat (3) tick;
        check("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        tick;
        rst_n = 1'b1;
        repeat (30) tick;
        run_frame(8'h6D, 16'h0F0F, 1, 8'hA5, 4, 1'b0, 1'b0, 1'b0);

        // Randomized frames
        for (int k = 0; k < 6; k++) begin
            ra = int'($urandom_range(0, MR + 1));
            rb = ($urandom_range(0, 1) == 1) ? ACK : 8'($urandom);
            rc = 8'($urandom);
            rd = 16'($urandom);
            run_frame(rc, rd, ra, rb, int'($urandom_range(1, 40)), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
